// File: rtl/quant_sched.sv
// Frame-level round-robin scheduler that shares one external quantizer
// between two sample producers and registers the results onto an output stream.
module quant_sched #(
    parameter int N         = 16,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    output logic [N-1:0] q_w,
    output logic         q_clear,
    input  logic [N-1:0] q_z,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_src,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic [7:0]   frame_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    state_t           state_nx;
    logic             owner;
    logic             rr;
    logic [CNT_W-1:0] cnt;
    logic             own_valid;
    logic             own_ready;
    logic             accept;
    logic             at_last;
    logic             pick;

    assign own_valid = owner ? req1_valid : req0_valid;
    assign own_ready = !out_valid || out_ready;
    assign accept    = (state == RUN) && own_valid && own_ready;
    assign at_last   = cnt == CNT_W'(FRAME_LEN - 1);
    // Round-robin preferred requester wins if valid, otherwise the other one.
    assign pick      = (rr ? req1_valid : req0_valid) ? rr : ~rr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (accept && at_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        q_clear    = 1'b1;
        q_w        = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = state != IDLE;
        if (state == RUN) begin
            q_clear    = 1'b0;
            q_w        = owner ? req1_data : req0_data;
            req0_ready = !owner && own_ready;
            req1_ready = owner && own_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            rr        <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (state == IDLE && (req0_valid || req1_valid)) begin
                owner <= pick;
                cnt   <= '0;
            end
            if (accept) begin
                out_data  <= q_z;
                out_valid <= 1'b1;
                out_src   <= owner;
                out_last  <= at_last;
                cnt       <= cnt + 1'b1;
                if (at_last) begin
                    rr        <= ~owner;
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quant_sched.sv
// Directed bench for quant_sched with a behavioural divide-by-3 quantizer
// and a negedge output monitor feeding a queue of handed-off samples.
module tb_quant_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [15:0] q_w, q_z;
    logic        q_clear;
    logic        out_valid, out_src, out_last, out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    int idx0 = 0;
    int idx1 = 0;
    logic [17:0] outq[$];

    always #5 clk = ~clk;

    quant_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .q_w(q_w), .q_clear(q_clear), .q_z(q_z),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    function automatic logic [7:0] qdiv(input logic [7:0] v);
        int t;
        t = int'($signed(v));
        return 8'(t / 3);
    endfunction

    assign q_z = {qdiv(q_w[15:8]), qdiv(q_w[7:0])};

    function automatic logic [15:0] gen(input int src, input int idx);
        int k;
        k = idx % 8;
        if (mode == 0) return (k % 2 == 1) ? 16'hF706 : 16'h0906;
        return {8'(3 * (k + 1) + 30 * src), 8'(-3 * (k + 1))};
    endfunction

    function automatic logic [17:0] exp_out(input int src, input int k);
        return {1'(src), k == 7, 8'(k + 1 + 10 * src), 8'(-(k + 1))};
    endfunction

    task automatic step();
        logic hs0, hs1;
        @(negedge clk);
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if (out_valid && out_ready) outq.push_back({out_src, out_last, out_data});
        @(posedge clk);
        #1;
        if (hs0) idx0++;
        if (hs1) idx1++;
        req0_data = gen(0, idx0);
        req1_data = gen(1, idx1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        idx0       = 0;
        idx1       = 0;
        req0_data  = gen(0, 0);
        req1_data  = gen(1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        outq.delete();
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (frame_cnt != 8'(target) && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (frame_cnt != 8'(target)) begin
            failures++;
            $display("FAIL run_until frame_cnt=%0d required=%0d", frame_cnt, target);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, q_clear, q_w, req0_ready, req1_ready, out_valid, frame_cnt}
            !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0}) begin
            failures++;
            $display("FAIL reset_state busy=%b clr=%b qw=%h rdy=%b%b ov=%b fc=%0d",
                     busy, q_clear, q_w, req0_ready, req1_ready, out_valid, frame_cnt);
        end
        checks++;
        if ({out_data, out_src, out_last} !== 18'h0) begin
            failures++;
            $display("FAIL reset_out data=%h src=%b last=%b required 0",
                     out_data, out_src, out_last);
        end
    endtask

    task automatic test_single();
        logic [15:0] e;
        do_reset();
        mode = 0;
        req0_data  = gen(0, 0);
        req0_valid = 1'b1;
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_accept ready=%b required 0", req0_ready);
        end
        step();
        checks++;
        if (q_clear !== 1'b0 || q_w !== 16'h0906 || busy !== 1'b1) begin
            failures++;
            $display("FAIL run_drive clr=%b qw=%h busy=%b required 0/0906/1",
                     q_clear, q_w, busy);
        end
        run_until(1);
        checks++;
        if (busy !== 1'b0 || q_clear !== 1'b1) begin
            failures++;
            $display("FAIL single_idle busy=%b clr=%b required 0/1", busy, q_clear);
        end
        checks++;
        if (outq.size() != 8) begin
            failures++;
            $display("FAIL single_count got=%0d required=8", outq.size());
        end
        for (int k = 0; k < 8 && outq.size() > 0; k++) begin
            e = (k % 2 == 1) ? 16'hFD02 : 16'h0302;
            checks++;
            if (outq[0] !== {1'b0, k == 7, e}) begin
                failures++;
                $display("FAIL single_out[%0d] got=%h required=%h", k, outq[0], {1'b0, k == 7, e});
            end
            void'(outq.pop_front());
        end
        mode = 1;
    endtask

    task automatic test_contention();
        int srcs[3] = '{0, 1, 0};
        logic r1_seen;
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        r1_seen = 1'b0;
        for (int n = 0; n < 40 && frame_cnt == 0; n++) begin
            step();
            if (req1_ready) r1_seen = 1'b1;
        end
        checks++;
        if (r1_seen !== 1'b0) begin
            failures++;
            $display("FAIL nonowner_ready req1_ready=1 seen during req0 frame, required 0");
        end
        run_until(3);
        checks++;
        if (outq.size() != 24) begin
            failures++;
            $display("FAIL contention_count got=%0d required=24", outq.size());
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8 && outq.size() > 0; k++) begin
                checks++;
                if (outq[0] !== exp_out(srcs[f], k)) begin
                    failures++;
                    $display("FAIL contention f%0d[%0d] got=%h required=%h",
                             f, k, outq[0], exp_out(srcs[f], k));
                end
                void'(outq.pop_front());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        do_reset();
        req0_valid = 1'b1;
        for (int n = 0; n < 20 && idx0 < 3; n++) step();
        out_ready = 1'b0;
        held = out_data;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (req0_ready !== 1'b0 || out_data !== held || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall[%0d] rdy=%b data=%h ov=%b required 0/%h/1",
                         n, req0_ready, out_data, out_valid, held);
            end
        end
        out_ready = 1'b1;
        run_until(1);
        checks++;
        if (outq.size() != 8) begin
            failures++;
            $display("FAIL stall_count got=%0d required=8", outq.size());
        end
        for (int k = 0; k < 8 && outq.size() > 0; k++) begin
            checks++;
            if (outq[0] !== exp_out(0, k)) begin
                failures++;
                $display("FAIL stall_out[%0d] got=%h required=%h", k, outq[0], exp_out(0, k));
            end
            void'(outq.pop_front());
        end
    endtask

    task automatic test_hold();
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int n = 0; n < 20 && idx0 < 4; n++) step();
        req0_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (req1_ready !== 1'b0 || busy !== 1'b1 || idx1 != 0) begin
                failures++;
                $display("FAIL hold[%0d] r1rdy=%b busy=%b idx1=%0d required 0/1/0",
                         n, req1_ready, busy, idx1);
            end
        end
        req0_valid = 1'b1;
        run_until(1);
        checks++;
        if (outq.size() != 8) begin
            failures++;
            $display("FAIL hold_count got=%0d required=8", outq.size());
        end
        for (int k = 0; k < 8 && outq.size() > 0; k++) begin
            checks++;
            if (outq[0] !== exp_out(0, k)) begin
                failures++;
                $display("FAIL hold_out[%0d] got=%h required=%h", k, outq[0], exp_out(0, k));
            end
            void'(outq.pop_front());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req0_valid = 1'b1;
        for (int n = 0; n < 20 && idx0 < 5; n++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, q_clear, out_data, frame_cnt, req0_ready}
            !== {1'b0, 1'b0, 1'b1, 16'h0, 8'h0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset ov=%b busy=%b clr=%b data=%h fc=%0d rdy=%b",
                     out_valid, busy, q_clear, out_data, frame_cnt, req0_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idx0 = 0;
        req0_data = gen(0, 0);
        outq.delete();
        run_until(1);
        checks++;
        if (outq.size() != 8) begin
            failures++;
            $display("FAIL rst_count got=%0d required=8", outq.size());
        end
        for (int k = 0; k < 8 && outq.size() > 0; k++) begin
            checks++;
            if (outq[0] !== exp_out(0, k)) begin
                failures++;
                $display("FAIL rst_out[%0d] got=%h required=%h", k, outq[0], exp_out(0, k));
            end
            void'(outq.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        logic        want_src;
        logic        saw255;
        int          frames;
        logic [7:0]  prev;
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        want_src = 1'b0;
        saw255 = 1'b0;
        frames = 0;
        prev = frame_cnt;
        for (int n = 0; n < 4000 && frames < 256; n++) begin
            step();
            if (frame_cnt != prev) begin
                frames++;
                if (frame_cnt == 8'd255) saw255 = 1'b1;
                checks++;
                if (frame_cnt !== 8'(prev + 1)) begin
                    failures++;
                    $display("FAIL frame_step got=%0d required=%0d", frame_cnt, 8'(prev + 1));
                end
                prev = frame_cnt;
            end
            while (outq.size() > 0) begin
                e = outq.pop_front();
                if (e[16]) begin
                    checks++;
                    if (e[17] !== want_src) begin
                        failures++;
                        $display("FAIL rr_src got=%b required=%b", e[17], want_src);
                    end
                    want_src = ~want_src;
                end
            end
        end
        checks++;
        if (!saw255 || frame_cnt !== 8'd0 || frames != 256) begin
            failures++;
            $display("FAIL frame_wrap saw255=%b fc=%0d frames=%0d required 1/0/256",
                     saw255, frame_cnt, frames);
        end
    endtask

    initial begin
        mode = 1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
